// File: rtl/uart_protocol.sv
// uart_protocol: parameterised UART transmitter.
// Each accepted request is sent as one frame: a start bit (0), DATA data bits LSB first,
// an optional parity bit, then STOP_BITS stop bits (1). Every line bit lasts
// CLKS_PER_BIT = CLK_FREQ / BAUD_RATE clocks.
//
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-low reset; aborts any frame and forces the line high
//   tx_start - transmit request, level-sensitive, sampled only while idle
//   data     - word to send, captured on the accepting edge
//   tx_out   - registered serial line, idles high
//   tx_busy  - registered, high from acceptance until the last stop bit completes
module uart_protocol #(
  parameter int unsigned DATA       = 8,
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            tx_start,
  input  logic [DATA-1:0] data,
  output logic            tx_out,
  output logic            tx_busy
);

  localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = 4;
  localparam logic [CntW-1:0] CntMax  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA - 1);
  localparam logic [BitW-1:0] LastStp = BitW'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("uart_protocol: CLK_FREQ / BAUD_RATE must be at least 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [BitW-1:0] bit_q, bit_d;
  logic [DATA-1:0] shift_q, shift_d;
  logic            par_q, par_d;
  logic            tx_q, tx_d;
  logic            busy_q, busy_d;
  logic            last_clk;

  assign last_clk = (cnt_q == CntMax);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    busy_d  = busy_q;

    if (state_q == StIdle) begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      if (tx_start) begin
        shift_d = data;
        par_d   = (^data) ^ (PARITY_ODD != 0);
        tx_d    = 1'b0;
        busy_d  = 1'b1;
        cnt_d   = '0;
        bit_d   = '0;
        state_d = StStart;
      end
    end else if (!last_clk) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      // Bit period over: decide what the line carries next.
      cnt_d = '0;
      unique case (state_q)
        StStart: begin
          tx_d    = shift_q[0];
          shift_d = shift_q >> 1;
          bit_d   = '0;
          state_d = StData;
        end
        StData: begin
          if (bit_q == LastBit) begin
            bit_d = '0;
            if (PARITY_EN != 0) begin
              tx_d    = par_q;
              state_d = StParity;
            end else begin
              tx_d    = 1'b1;
              state_d = StStop;
            end
          end else begin
            tx_d    = shift_q[0];
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 1'b1;
          end
        end
        StParity: begin
          tx_d    = 1'b1;
          bit_d   = '0;
          state_d = StStop;
        end
        StStop: begin
          if (bit_q == LastStp) begin
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            bit_d   = '0;
            state_d = StIdle;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        default: begin
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_out  = tx_q;
  assign tx_busy = busy_q;

endmodule

// File: tb/tb_uart_protocol.sv
// Self-checking bench for uart_protocol: one default-rate instance and two fast
// instances (4 clocks/bit, parity, 2 stop bits; even and odd parity).
module tb_uart_protocol;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic       reset;
  logic       st0, st1, st2;
  logic [7:0] d0, d1, d2;
  logic       tx0, tx1, tx2, b0, b1, b2;
  int         cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  uart_protocol u_dut0 (
    .clk(clk), .reset(reset), .tx_start(st0), .data(d0), .tx_out(tx0), .tx_busy(b0)
  );

  uart_protocol #(
    .CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)
  ) u_dut1 (
    .clk(clk), .reset(reset), .tx_start(st1), .data(d1), .tx_out(tx1), .tx_busy(b1)
  );

  uart_protocol #(
    .CLK_FREQ(16), .BAUD_RATE(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2)
  ) u_dut2 (
    .clk(clk), .reset(reset), .tx_start(st2), .data(d2), .tx_out(tx2), .tx_busy(b2)
  );

  int   sel = 0;
  logic mon_tx, mon_busy;
  always_comb begin
    mon_tx   = tx0;
    mon_busy = b0;
    if (sel == 1) begin
      mon_tx   = tx1;
      mon_busy = b1;
    end else if (sel == 2) begin
      mon_tx   = tx2;
      mon_busy = b2;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line configuration of each instance.
  function automatic int cfg_cpb(input int s);
    return (s == 0) ? 434 : 4;
  endfunction

  // Reference frame: list of line levels, one per bit period.
  function automatic logic [15:0] model_frame(input int s, input logic [7:0] d, output int n);
    logic [15:0] f;
    int          ones;
    f    = '0;
    ones = 0;
    f[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      f[1 + i] = d[i];
      ones += int'(d[i]);
    end
    n = 9;
    if (s != 0) begin
      f[n] = ((ones % 2) == 1) ^ (s == 2);
      n++;
    end
    for (int k = 0; k < ((s == 0) ? 1 : 2); k++) begin
      f[n] = 1'b1;
      n++;
    end
    return f;
  endfunction

  task automatic issue(input int s, input logic [7:0] d, input int hold);
    @(negedge clk);
    case (s)
      0: begin st0 = 1'b1; d0 = d; end
      1: begin st1 = 1'b1; d1 = d; end
      default: begin st2 = 1'b1; d2 = d; end
    endcase
    repeat (hold) @(negedge clk);
    case (s)
      0: st0 = 1'b0;
      1: st1 = 1'b0;
      default: st2 = 1'b0;
    endcase
  endtask

  // Waits for a start bit, checks every clock of the frame against the model, and
  // returns the mid-bit samples.
  task automatic run_frame(input int s, input logic [7:0] d, output logic [15:0] got);
    logic [15:0] exp;
    int          n, cpb, bad_cyc;
    bit          found, wave_ok;
    sel     = s;
    cpb     = cfg_cpb(s);
    exp     = model_frame(s, d, n);
    got     = '0;
    found   = 1'b0;
    wave_ok = 1'b1;
    bad_cyc = -1;
    for (int t = 0; t < 20000; t++) begin
      @(negedge clk);
      if (mon_tx === 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check("start_seen", 32'(found), 32'd1);
    if (!found) return;
    for (int c = 0; c < n * cpb; c++) begin
      if (c > 0) @(negedge clk);
      if ((mon_tx !== exp[c / cpb]) || (mon_busy !== 1'b1)) begin
        if (wave_ok) bad_cyc = c;
        wave_ok = 1'b0;
      end
      if ((c % cpb) == cpb / 2) got[c / cpb] = mon_tx;
    end
    check("frame_wave", 32'(wave_ok), 32'd1);
    if (!wave_ok) $display("  first deviation at frame clock %0d", bad_cyc);
    @(negedge clk);
    check("frame_end_busy_tx", {30'd0, mon_busy, mon_tx}, 32'b01);
    check("decoded", {24'd0, got[8:1]}, {24'd0, d});
  endtask

  task automatic check_quiet(input int cycles);
    bit ok = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if ((mon_tx !== 1'b1) || (mon_busy !== 1'b0)) ok = 1'b0;
    end
    check("no_extra_frame", 32'(ok), 32'd1);
  endtask

  typedef struct {
    int         s;
    logic [7:0] d;
    int         hold;
    int         par;   // expected parity bit, -1 when the instance has none
  } vec_t;

  vec_t        tbl[10];
  logic [15:0] got;
  int          t0;

  initial begin
    tbl[0] = '{0, 8'hD3, 2, -1};
    tbl[1] = '{0, 8'hA5, 1, -1};
    tbl[2] = '{0, 8'h3C, 1, -1};
    tbl[3] = '{0, 8'h55, 1, -1};
    tbl[4] = '{1, 8'h55, 1, 0};
    tbl[5] = '{2, 8'h55, 1, 1};
    tbl[6] = '{1, 8'h00, 1, 0};
    tbl[7] = '{2, 8'h00, 1, 1};
    tbl[8] = '{1, 8'h01, 3, 1};
    tbl[9] = '{2, 8'h01, 2, 0};

    st0 = 1'b1; st1 = 1'b1; st2 = 1'b1;
    d0 = 8'hFF; d1 = 8'hFF; d2 = 8'hFF;
    reset = 1'b0;

    // Reset holds everything idle even with tx_start high.
    repeat (2) begin
      @(negedge clk);
      check("reset_idle", {29'd0, tx0 & tx1 & tx2, b0 | b1 | b2}, 32'b10);
    end
    st0 = 1'b0; st1 = 1'b0; st2 = 1'b0;
    reset = 1'b1;
    sel = 0;
    check_quiet(5);

    // Table frames; the first four form the back-to-back default-rate sequence.
    t0 = cyc;
    for (int i = 0; i < 10; i++) begin
      fork
        issue(tbl[i].s, tbl[i].d, tbl[i].hold);
        run_frame(tbl[i].s, tbl[i].d, got);
      join
      if (tbl[i].par >= 0) check("parity_bit", {31'd0, got[9]}, 32'(tbl[i].par));
      if (i == 3) check("four_frames_in_2ms", 32'((cyc - t0) < 100000), 32'd1);
      check_quiet((tbl[i].s == 0) ? 300 : 12);
    end

    // Request and data change while busy are ignored.
    fork
      run_frame(0, 8'hA5, got);
      begin
        issue(0, 8'hA5, 1);
        repeat (2000) @(negedge clk);
        issue(0, 8'hFF, 1);
      end
    join
    check_quiet(900);

    // Asynchronous abort during the third data bit.
    sel = 0;
    fork
      issue(0, 8'hD3, 1);
      begin
        bit seen = 1'b0;
        for (int t = 0; t < 100; t++) begin
          @(negedge clk);
          if (tx0 === 1'b0) begin
            seen = 1'b1;
            break;
          end
        end
        check("abort_frame_started", 32'(seen), 32'd1);
      end
    join
    repeat (3 * 434 + 200) @(negedge clk);
    check("abort_pre_busy", {31'd0, b0}, 32'd1);
    #3 reset = 1'b0;
    #1 check("abort_async", {30'd0, tx0, b0}, 32'b10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check_quiet(500);
    fork
      issue(0, 8'h3C, 1);
      run_frame(0, 8'h3C, got);
    join

    // tx_start held high: next frame begins after exactly one idle clock.
    sel = 1;
    @(negedge clk);
    st1 = 1'b1;
    d1  = 8'h55;
    run_frame(1, 8'h55, got);
    @(negedge clk);
    check("held_restart", {30'd0, b1, tx1}, 32'b10);
    st1 = 1'b0;
    begin
      bit done = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge clk);
        if (b1 === 1'b0) begin
          done = 1'b1;
          break;
        end
      end
      check("held_second_done", 32'(done), 32'd1);
    end

    // Randomised frames against the reference model.
    for (int i = 0; i < 40; i++) begin
      int         s;
      logic [7:0] d;
      s = 1 + (i % 2);
      d = 8'($urandom);
      fork
        issue(s, d, $urandom_range(1, 4));
        run_frame(s, d, got);
      join
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    for (int i = 0; i < 2; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      fork
        issue(0, d, $urandom_range(1, 10));
        run_frame(0, d, got);
      join
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_protocol.md
Name: uart_protocol

Overview:
Parameterised UART transmitter. It serialises one DATA-bit word per request onto a single line as start bit, data LSB-first, optional parity and stop bit(s). It sits between a parallel producer that issues a tx_start/data request and the off-chip TX pin, and reports tx_busy so the producer can pace requests.

Parameters:
DATA, 8, data bits per frame (5..9 legal).
CLK_FREQ, 50_000_000, clk frequency in Hz.
BAUD_RATE, 115200, line bit rate in bit/s.
PARITY_EN, 0, 1 inserts a parity bit after the data bits.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0).
STOP_BITS, 1, number of stop bits (1 or 2).
Derived localparam CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer division; 434 at defaults). Elaboration fails if CLKS_PER_BIT < 2.

Ports:
clk  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-low reset (0 = reset asserted).
tx_start  input  1  transmit request, sampled only while idle.
data  input  DATA  word to send, captured on the accepting edge.
tx_out  output  1  serial line, idles high.
tx_busy  output  1  high from acceptance until the frame (incl. stop bits) completes.

Behaviour:
- Reset (reset=0, asynchronous): tx_out=1, tx_busy=0, state=IDLE, bit/clock counters=0, shift register=0. An in-progress frame is aborted immediately. tx_out is high throughout reset.
- States: IDLE, START, DATA_BITS, PARITY (only when PARITY_EN=1), STOP, then back to IDLE.
- IDLE: tx_out=1, tx_busy=0.
  - Rising edge with tx_start=1: latch data into the shift register, compute the parity bit, and enter START.
  - On the same edge, tx_out<=0 and tx_busy<=1 (both registered, so visible one edge after the request).
- Each line bit is held for exactly CLKS_PER_BIT clocks, timed by a clock counter running 0..CLKS_PER_BIT-1.
- START: after CLKS_PER_BIT clocks, drive data[0] and enter DATA_BITS.
- DATA_BITS: bits are sent LSB first, data[0]..data[DATA-1].
  - After the last bit, go to PARITY if PARITY_EN=1, otherwise to STOP.
- PARITY: bit is the XOR of the latched data, inverted when PARITY_ODD=1.
- STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT clocks, then IDLE.
  - On the edge that enters IDLE, tx_busy<=0.
- Frame length is CLKS_PER_BIT*(1+DATA+PARITY_EN+STOP_BITS) clocks, measured from the tx_out falling edge to the tx_busy falling edge.
- tx_start is level-sensitive but is sampled only in IDLE.
  - Held high for several cycles, it produces exactly one frame, because it is ignored once busy.
  - Still high when the frame ends, it starts the next frame after exactly one IDLE clock (tx_out=1, tx_busy=0 for that clock).
- Changes on data after acceptance do not affect the frame in flight.
- Reset released mid-line: the block resumes in IDLE with no partial frame.

Test Plan:
1. Reset check: hold reset=0 for 2 clocks with tx_start=1 -> tx_out=1 and tx_busy=0 throughout. After release with tx_start=0, still idle.
2. Single frame, defaults (20 ns clk): data=8'hD3, tx_start pulsed 2 clocks.
   - tx_busy rises one edge later.
   - tx_out = 0,1,1,0,0,1,0,1,1,1, each bit held 434 clocks.
   - tx_busy falls 4340 clocks after the start bit.
   - Exactly one frame is sent.
3. Four-frame sequence: D3, A5, 3C, 55, each issued after waiting for tx_busy=0.
   - Decoded bytes are D3, A5, 3C, 55 in order.
   - Every frame is 4340 clocks long.
   - All four frames complete within 2 ms.
4. Request while busy: pulse tx_start with data=8'hFF mid-frame of 8'hA5 -> the frame still decodes as A5 and no extra frame follows.
5. Abort: assert reset during the third data bit -> tx_out=1 and tx_busy=0 immediately (asynchronously). After release, a new 8'h3C frame is sent cleanly.
6. Config build CLK_FREQ=16, BAUD_RATE=4 (CLKS_PER_BIT=4), PARITY_EN=1, STOP_BITS=2:
   - data=8'h55 gives parity bit 0 (even) and a frame of 4*12=48 clocks.
   - With PARITY_ODD=1 the parity bit is 1.
   - With tx_start held high, the next frame starts after exactly one idle clock.
